// File: rtl/shift_register_tx_sequencer_pkg.sv
// shift_ctrl_pkg: state encoding and width helper shared by the tx sequencer.
// Contents: STATE_W, state_e (IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH), clog2().
package shift_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        SHIFT_LO = 3'd2,
        SHIFT_HI = 3'd3,
        LATCH    = 3'd4
    } state_e;

    // Bits needed to count 0..v-1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/shift_register_tx_sequencer_if.sv
// Host-side word handshake of the tx sequencer.
// Signals: tx_valid/tx_data/tx_ready word transfer, abort, tx_done frame pulse.
interface shift_register_tx_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             tx_valid;
    logic [WIDTH-1:0] tx_data;
    logic             tx_ready;
    logic             abort;
    logic             tx_done;

    modport master (
        output tx_valid, tx_data, abort,
        input  tx_ready, tx_done
    );

    modport slave (
        input  tx_valid, tx_data, abort,
        output tx_ready, tx_done
    );
endinterface

// File: rtl/shift_register_tx_sequencer_div.sv
// sclk_div_counter: counts 0..DIV-1 and flags the terminal count.
// Ports: clk, rst_n (async, active low), clear_i (sync clear), tick_o.
module sclk_div_counter
    import shift_ctrl_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    output logic tick_o
);
    localparam int CW = (DIV > 1) ? clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = !clear_i && (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear_i || tick_o) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/shift_register_tx_sequencer.sv
// shift_register_tx_sequencer: parallel-loads a host word into an external shift
// register, clocks it out MSB-first on sclk/sdo, then strobes latch.
// Ports: clk, resetn (async, active low); tx = host handshake (valid/ready/data,
// abort, tx_done); sr_enable/sr_select/sr_d drive the register, sr_q returns
// its outputs; sdo = sr_q MSB; sclk idles low; latch strobes after the last bit.
// Option SHIFT_CTRL_HOLD_EN: one-word holding register for back-to-back frames.
module shift_register_tx_sequencer
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int DIV          = 4,
    parameter int LATCH_CYCLES = 1
) (
    input  logic                         clk,
    input  logic                         resetn,
    shift_register_tx_sequencer_if.slave tx,
    output logic                         sr_enable,
    output logic                         sr_select,
    output logic [WIDTH-1:0]             sr_d,
    input  logic [WIDTH-1:0]             sr_q,
    output logic                         sclk,
    output logic                         sdo,
    output logic                         latch
);
    localparam int BW = clog2(WIDTH);
    localparam int LW = clog2(LATCH_CYCLES + 1);

    state_e           state_q, state_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [LW-1:0]    lat_q, lat_d;
    logic [WIDTH-1:0] load_w;
    logic             acc, abort_hit, tick, div_clr, last_bit, lat_last;
    logic             tx_ready_q, tx_ready_d;
    logic             tx_done_q, tx_done_d;
    logic             sr_enable_q, sr_enable_d;
    logic             sr_select_q, sr_select_d;
    logic [WIDTH-1:0] sr_d_q, sr_d_d;
    logic             sclk_q, sclk_d;
    logic             latch_q, latch_d;
`ifdef SHIFT_CTRL_HOLD_EN
    logic             hold_v_q, hold_v_d;
    logic [WIDTH-1:0] hold_w_q, hold_w_d;
`endif
    logic             unused_sr_q;

    assign acc       = tx.tx_valid & tx_ready_q;
    assign abort_hit = tx.abort & (state_q != IDLE);
    assign last_bit  = (bit_q == BW'(WIDTH - 1));
    assign lat_last  = (state_q == LATCH) && (lat_q == LW'(LATCH_CYCLES - 1));
    assign div_clr   = (state_q != SHIFT_LO) && (state_q != SHIFT_HI);

    sclk_div_counter #(.DIV(DIV)) u_div (
        .clk    (clk),
        .rst_n  (resetn),
        .clear_i(div_clr),
        .tick_o (tick)
    );

    // Next state, bit/latch counters and the word headed into LOAD.
    always_comb begin
        state_d = state_q;
        load_w  = tx.tx_data;
        bit_d   = bit_q;
        lat_d   = (state_q == LATCH) ? lat_q + LW'(1) : '0;
`ifdef SHIFT_CTRL_HOLD_EN
        hold_v_d = hold_v_q;
        hold_w_d = hold_w_q;
`endif
        unique case (state_q)
            IDLE:     if (acc) state_d = LOAD;
            LOAD:     state_d = SHIFT_LO;
            SHIFT_LO: if (tick) state_d = SHIFT_HI;
            SHIFT_HI: if (tick) state_d = last_bit ? LATCH : SHIFT_LO;
            LATCH:    if (lat_last) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
`ifdef SHIFT_CTRL_HOLD_EN
        // Words arriving mid-frame park in the hold; drain it without an idle gap.
        if (acc && state_q != IDLE) begin
            hold_v_d = 1'b1;
            hold_w_d = tx.tx_data;
        end
        if (lat_last && hold_v_d) begin
            state_d  = LOAD;
            load_w   = hold_w_d;
            hold_v_d = 1'b0;
        end
`endif
        if (abort_hit) begin
            state_d = IDLE;
`ifdef SHIFT_CTRL_HOLD_EN
            hold_v_d = 1'b0;
`endif
        end
        if (state_d == LOAD) bit_d = '0;
        else if (state_q == SHIFT_HI && state_d == SHIFT_LO) bit_d = bit_q + BW'(1);
    end

    // Registered outputs are derived from the state being entered.
    always_comb begin
`ifdef SHIFT_CTRL_HOLD_EN
        tx_ready_d = !hold_v_d;
`else
        tx_ready_d = (state_d == IDLE);
`endif
        // Shift pulse lands with sclk falling, i.e. on re-entry to SHIFT_LO.
        sr_enable_d = (state_d == LOAD) ||
                      (state_q == SHIFT_HI && state_d == SHIFT_LO);
        sr_select_d = (state_d == LOAD);
        sr_d_d      = (state_d == LOAD) ? load_w : '0;
        sclk_d      = (state_d == SHIFT_HI);
        latch_d     = (state_d == LATCH);
        tx_done_d   = (state_d == LATCH) && (lat_d == LW'(LATCH_CYCLES - 1));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            bit_q       <= '0;
            lat_q       <= '0;
            tx_ready_q  <= 1'b1;
            tx_done_q   <= 1'b0;
            sr_enable_q <= 1'b0;
            sr_select_q <= 1'b0;
            sr_d_q      <= '0;
            sclk_q      <= 1'b0;
            latch_q     <= 1'b0;
`ifdef SHIFT_CTRL_HOLD_EN
            hold_v_q    <= 1'b0;
            hold_w_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            bit_q       <= bit_d;
            lat_q       <= lat_d;
            tx_ready_q  <= tx_ready_d;
            tx_done_q   <= tx_done_d;
            sr_enable_q <= sr_enable_d;
            sr_select_q <= sr_select_d;
            sr_d_q      <= sr_d_d;
            sclk_q      <= sclk_d;
            latch_q     <= latch_d;
`ifdef SHIFT_CTRL_HOLD_EN
            hold_v_q    <= hold_v_d;
            hold_w_q    <= hold_w_d;
`endif
        end
    end

    assign tx.tx_ready = tx_ready_q;
    assign tx.tx_done  = tx_done_q;
    assign sr_enable   = sr_enable_q;
    assign sr_select   = sr_select_q;
    assign sr_d        = sr_d_q;
    assign sclk        = sclk_q;
    assign latch       = latch_q;
    assign sdo         = sr_q[WIDTH-1];
    assign unused_sr_q = ^sr_q[WIDTH-2:0];
endmodule
